// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: word type, counter width and a
// saturating-increment helper used by the transfer counters.
package cpu_pkg;

    localparam int WORD_W = 24;
    localparam int CNT_W  = 16;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    localparam cnt_t CNT_MAX = {CNT_W{1'b1}};

    // Increment by one when inc is set, holding at CNT_MAX instead of wrapping.
    function automatic cnt_t cnt_sat_inc(input cnt_t value, input logic inc);
        cnt_t result;
        if (inc && (value != CNT_MAX)) begin
            result = value + cnt_t'(1'b1);
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/demux_fifo.sv
// Small synchronous FIFO used once per demux output.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter. Storage is not reset: a word is
// only ever observed after it has been written.
module demux_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic             push_ok_s;
    logic             pop_ok_s;
    logic [AW-1:0]    wr_idx_s;
    logic [AW-1:0]    rd_idx_s;

    assign wr_idx_s  = wr_ptr_q[AW-1:0];
    assign rd_idx_s  = rd_ptr_q[AW-1:0];

    // Flags depend only on the registered pointers.
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                       (wr_idx_s == rd_idx_s);
    assign head_data = mem_q[rd_idx_s];

    // Never write into a full FIFO or read from an empty one, whatever the caller does.
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Next pointer values: each advances by one per accepted operation.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Next storage contents: write the pushed word into the tail slot.
    always_comb begin
        mem_d = mem_q;
        if (push_ok_s) begin
            mem_d[wr_idx_s] = push_data;
        end else begin
            mem_d = mem_q;
        end
    end

    // Pointer registers, cleared asynchronously so the FIFO empties at once on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage registers, deliberately without reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/demux_1to2_buf.sv
// Buffered 1-to-2 demultiplexer. Each accepted word is steered by S into
// one of two output FIFOs; a stalled consumer only blocks words bound for
// its own FIFO. Input ready looks only at the selected FIFO's full flag
// and never at the consumer ready inputs.
// Optional feature macro: DEMUX_COUNT_EN adds saturating 16-bit counters
// of completed output transfers (Numeruesi0 / Numeruesi1).
module demux_1to2_buf
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = 2
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] Hyrja,
    input  logic             S,
    input  logic             Hyrja_valid,
    output logic             Hyrja_ready,
    output logic [WIDTH-1:0] Dalja0,
    output logic             Dalja0_valid,
    input  logic             Dalja0_ready,
    output logic [WIDTH-1:0] Dalja1,
    output logic             Dalja1_valid,
    input  logic             Dalja1_ready
`ifdef DEMUX_COUNT_EN
    ,
    output logic [CNT_W-1:0] Numeruesi0,
    output logic [CNT_W-1:0] Numeruesi1
`endif
);

    logic full0_s;
    logic full1_s;
    logic empty0_s;
    logic empty1_s;
    logic accept_s;
    logic push0_s;
    logic push1_s;
    logic pop0_s;
    logic pop1_s;

    // Input handshake and steering toward the FIFO chosen by S.
    always_comb begin
        Hyrja_ready = 1'b0;
        accept_s    = 1'b0;
        push0_s     = 1'b0;
        push1_s     = 1'b0;
        if (S) begin
            Hyrja_ready = !full1_s;
        end else begin
            Hyrja_ready = !full0_s;
        end
        accept_s = Hyrja_valid && Hyrja_ready;
        if (accept_s) begin
            push0_s = !S;
            push1_s = S;
        end else begin
            push0_s = 1'b0;
            push1_s = 1'b0;
        end
    end

    // Output handshakes: a FIFO pops when it is non-empty and its consumer accepts.
    always_comb begin
        Dalja0_valid = !empty0_s;
        Dalja1_valid = !empty1_s;
        pop0_s       = Dalja0_valid && Dalja0_ready;
        pop1_s       = Dalja1_valid && Dalja1_ready;
    end

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk       (Clock),
        .rst_n     (Reset_n),
        .push      (push0_s),
        .push_data (Hyrja),
        .full      (full0_s),
        .pop       (pop0_s),
        .head_data (Dalja0),
        .empty     (empty0_s)
    );

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk       (Clock),
        .rst_n     (Reset_n),
        .push      (push1_s),
        .push_data (Hyrja),
        .full      (full1_s),
        .pop       (pop1_s),
        .head_data (Dalja1),
        .empty     (empty1_s)
    );

`ifdef DEMUX_COUNT_EN
    cnt_t cnt0_q;
    cnt_t cnt0_d;
    cnt_t cnt1_q;
    cnt_t cnt1_d;

    // Next counter values: count completed output transfers, holding at all-ones.
    always_comb begin
        cnt0_d = cnt_sat_inc(cnt0_q, pop0_s);
        cnt1_d = cnt_sat_inc(cnt1_q, pop1_s);
    end

    // Transfer counter registers.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign Numeruesi0 = cnt0_q;
    assign Numeruesi1 = cnt1_q;
`endif

endmodule

// File: tb/tb_demux_1to2_buf.sv
// Self-checking bench for demux_1to2_buf: a queue-based reference model is
// compared against the DUT on every falling edge, plus directed scenarios
// with literal expectations.
module tb_demux_1to2_buf;

    localparam int W     = 24;
    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] hyrja = '0;
    logic         s = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] d0;
    logic         d0_valid;
    logic         d0_ready = 1'b0;
    logic [W-1:0] d1;
    logic         d1_valid;
    logic         d1_ready = 1'b0;
`ifdef DEMUX_COUNT_EN
    logic [15:0]  n0;
    logic [15:0]  n1;
`endif

    demux_1to2_buf #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .Clock        (clk),
        .Reset_n      (rst_n),
        .Hyrja        (hyrja),
        .S            (s),
        .Hyrja_valid  (in_valid),
        .Hyrja_ready  (in_ready),
        .Dalja0       (d0),
        .Dalja0_valid (d0_valid),
        .Dalja0_ready (d0_ready),
        .Dalja1       (d1),
        .Dalja1_valid (d1_valid),
        .Dalja1_ready (d1_ready)
`ifdef DEMUX_COUNT_EN
        ,
        .Numeruesi0   (n0),
        .Numeruesi1   (n1)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    // Reference model: one queue per output plus transfer counts.
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    int unsigned  c0 = 0;
    int unsigned  c1 = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model update on each clock edge, emptied immediately on reset.
    always @(posedge clk or negedge rst_n) begin
        bit pop0;
        bit pop1;
        bit rdy;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            c0 = 0;
            c1 = 0;
        end else begin
            pop0 = (q0.size() != 0) && d0_ready;
            pop1 = (q1.size() != 0) && d1_ready;
            rdy  = s ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
            if (pop0) begin
                void'(q0.pop_front());
                if (c0 != 65535) c0++;
            end
            if (pop1) begin
                void'(q1.pop_front());
                if (c1 != 65535) c1++;
            end
            if (in_valid && rdy) begin
                if (s) q1.push_back(hyrja);
                else   q0.push_back(hyrja);
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("valid0", 32'(d0_valid), 32'(q0.size() != 0));
            check("valid1", 32'(d1_valid), 32'(q1.size() != 0));
            if (q0.size() != 0) check("data0", 32'(d0), 32'(q0[0]));
            if (q1.size() != 0) check("data1", 32'(d1), 32'(q1[0]));
            check("in_ready", 32'(in_ready),
                  32'(s ? (q1.size() < DEPTH) : (q0.size() < DEPTH)));
`ifdef DEMUX_COUNT_EN
            check("count0", 32'(n0), c0);
            check("count1", 32'(n1), c1);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    bit accepted;

    initial begin
        // Reset and reset-state literals
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        #1;
        check("rst_valid0", 32'(d0_valid), 32'd0);
        check("rst_valid1", 32'(d1_valid), 32'd0);
        check("rst_ready_s0", 32'(in_ready), 32'd1);
        s = 1'b1;
        #1;
        check("rst_ready_s1", 32'(in_ready), 32'd1);
        s = 1'b0;
        tick();

        // T1: one word to each output, one-cycle latency
        d0_ready = 1'b1; d1_ready = 1'b1;
        in_valid = 1'b1; s = 1'b0; hyrja = 24'h000001;
        tick();
        check("t1_valid0", 32'(d0_valid), 32'd1);
        check("t1_data0", 32'(d0), 32'h000001);
        s = 1'b1; hyrja = 24'h000002;
        tick();
        check("t1_valid0_drop", 32'(d0_valid), 32'd0);
        check("t1_valid1", 32'(d1_valid), 32'd1);
        check("t1_data1", 32'(d1), 32'h000002);
        in_valid = 1'b0;
        tick();
        check("t1_valid1_drop", 32'(d1_valid), 32'd0);

        // T2: fill FIFO 0, other output still accepts
        d0_ready = 1'b0;
        in_valid = 1'b1; s = 1'b0; hyrja = 24'hA00000;
        tick();
        hyrja = 24'hA00001;
        tick();
        in_valid = 1'b0; s = 1'b0;
        #1;
        check("t2_full_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1; s = 1'b1; hyrja = 24'hB00000;
        #1;
        check("t2_ready_s1", 32'(in_ready), 32'd1);
        tick();
        check("t2_valid1", 32'(d1_valid), 32'd1);
        check("t2_data1", 32'(d1), 32'hB00000);
        in_valid = 1'b0;
        tick();

        // T3: no look-ahead on full; order A00000, A00001, C00000
        in_valid = 1'b1; s = 1'b0; hyrja = 24'hC00000; d0_ready = 1'b1;
        #1;
        check("t3_no_lookahead", 32'(in_ready), 32'd0);
        tick();
        check("t3_head_a1", 32'(d0), 32'hA00001);
        check("t3_ready_after_pop", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("t3_valid_c", 32'(d0_valid), 32'd1);
        check("t3_head_c", 32'(d0), 32'hC00000);
        tick();
        check("t3_empty", 32'(d0_valid), 32'd0);

        // T4: back-to-back words across pointer wrap
        d1_ready = 1'b1; in_valid = 1'b1; s = 1'b1;
        for (int i = 0; i < 2 * DEPTH + 3; i++) begin
            hyrja = 24'h000010 + 24'(i);
            tick();
            check("t4_valid1", 32'(d1_valid), 32'd1);
            check("t4_data1", 32'(d1), 32'h10 + 32'(i));
        end
        in_valid = 1'b0;
        tick();
        check("t4_drain", 32'(d1_valid), 32'd0);

        // T5: asynchronous reset with both FIFOs holding data
        d0_ready = 1'b0; d1_ready = 1'b0; in_valid = 1'b1;
        s = 1'b0; hyrja = 24'hD00000; tick();
        hyrja = 24'hD00001; tick();
        s = 1'b1; hyrja = 24'hE00000; tick();
        hyrja = 24'hE00001; tick();
        in_valid = 1'b0;
        check("t5_pre_valid0", 32'(d0_valid), 32'd1);
        check("t5_pre_valid1", 32'(d1_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid0", 32'(d0_valid), 32'd0);
        check("t5_rst_valid1", 32'(d1_valid), 32'd0);
        s = 1'b0;
        #1;
        check("t5_rst_ready_s0", 32'(in_ready), 32'd1);
        s = 1'b1;
        #1;
        check("t5_rst_ready_s1", 32'(in_ready), 32'd1);
        #1;
        rst_n = 1'b1;
        tick();
        check("t5_post_valid0", 32'(d0_valid), 32'd0);
        check("t5_post_valid1", 32'(d1_valid), 32'd0);

`ifdef DEMUX_COUNT_EN
        // T6: transfer counters and saturation
        d0_ready = 1'b1; d1_ready = 1'b1; in_valid = 1'b1; s = 1'b0;
        for (int i = 0; i < 5; i++) begin hyrja = 24'($urandom); tick(); end
        s = 1'b1;
        for (int i = 0; i < 3; i++) begin hyrja = 24'($urandom); tick(); end
        in_valid = 1'b0;
        tick(); tick();
        check("t6_cnt0", 32'(n0), 32'd5);
        check("t6_cnt1", 32'(n1), 32'd3);
        in_valid = 1'b1; s = 1'b0;
        for (int i = 0; i < 65529; i++) begin hyrja = 24'(i); tick(); end
        in_valid = 1'b0;
        tick();
        check("t6_cnt0_fffe", 32'(n0), 32'h0000FFFE);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin hyrja = 24'(i); tick(); end
        in_valid = 1'b0;
        tick();
        check("t6_cnt0_sat", 32'(n0), 32'h0000FFFF);
`endif

        // Random phase: protocol-respecting producer, varying consumer pressure
        in_valid = 1'b0;
        accepted = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!in_valid || accepted) begin
                in_valid = ($urandom_range(0, 3) != 0);
                hyrja    = 24'($urandom);
                s        = 1'($urandom_range(0, 1));
            end
            if (((cyc / 300) % 2) == 1) begin
                d0_ready = ($urandom_range(0, 4) == 0);
                d1_ready = ($urandom_range(0, 1) == 0);
            end else begin
                d0_ready = ($urandom_range(0, 3) != 0);
                d1_ready = ($urandom_range(0, 3) != 0);
            end
            if (cyc == 1500) begin
                #1;
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
                in_valid = 1'b0;
            end
            @(negedge clk);
            accepted = in_valid && in_ready;
            tick();
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
